// File: rtl/attack_board_parser_pkg.sv
// Shared constants, parser state enum and a character helper for the board-text blocks.
// Shared by the attack-display blocks and the board-text parsers.
package attack_board_parser_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_CR    = 8'h0D;
  localparam logic [7:0] CHAR_LF    = 8'h0A;
  localparam logic [7:0] CHAR_TAB   = 8'h09;

  localparam int SIDE_WIDTH    = 8;
  localparam int BOARD_SQUARES = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } parse_state_t;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) ? (c + 8'h20) : c;
  endfunction

endpackage

// File: rtl/attack_board_parser_classify.sv
// Combinational byte classifier: set square, clear square, whitespace or illegal.
// Zero latency; no flow control of its own.
module attack_char_classify
  import attack_board_parser_pkg::*;
#(
  parameter logic [7:0] SET_CHAR   = 8'h58,
  parameter logic [7:0] CLEAR_CHAR = 8'h2E,
  parameter bit         CASE_FOLD  = 1'b1
) (
  input  logic [7:0] ch,
  output logic       is_set,
  output logic       is_clear,
  output logic       is_space,
  output logic       is_illegal
);

  localparam logic [7:0] SET_LOWER = to_lower(SET_CHAR);

  always_comb begin
    is_set     = (ch == SET_CHAR) || (CASE_FOLD && (ch == SET_LOWER));
    // Set wins if the two parameters were ever configured to overlap.
    is_clear   = (ch == CLEAR_CHAR) && !is_set;
    is_space   = (ch == CHAR_SPACE) || (ch == CHAR_CR) ||
                 (ch == CHAR_LF)    || (ch == CHAR_TAB);
    is_illegal = !(is_set || is_clear || is_space);
  end

endmodule

// File: rtl/attack_board_parser.sv
// Rebuilds a 64-bit attack bitboard from its printed text form (first square = bit 56).
// Optional ATTACK_BOARD_POPCOUNT_EN adds attack_count; stalls input for one cycle in DONE/ERR.
module attack_board_parser
  import attack_board_parser_pkg::*;
#(
  parameter logic [7:0] SET_CHAR   = 8'h58,
  parameter logic [7:0] CLEAR_CHAR = 8'h2E,
  parameter bit         CASE_FOLD  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [63:0] bitboard,
  output logic        bitboard_valid,
  output logic        parse_error,
`ifdef ATTACK_BOARD_POPCOUNT_EN
  output logic [6:0]  attack_count,
`endif
  output logic        busy
);

  parse_state_t state, state_nxt;
  logic [63:0]  shadow, shadow_nxt;
  logic [5:0]   index, row_start;
  logic [2:0]   col;
  logic         is_set, is_clear, is_space, is_illegal;
  logic         accept, is_square, last_square;

  attack_char_classify #(
    .SET_CHAR   (SET_CHAR),
    .CLEAR_CHAR (CLEAR_CHAR),
    .CASE_FOLD  (CASE_FOLD)
  ) u_classify (
    .ch         (char_in),
    .is_set     (is_set),
    .is_clear   (is_clear),
    .is_space   (is_space),
    .is_illegal (is_illegal)
  );

  assign char_ready     = !reset && ((state == IDLE) || (state == RECV));
  assign accept         = char_valid && char_ready;
  assign is_square      = is_set || is_clear;
  // The 64th square is the last column of the bottom rank.
  assign last_square    = (row_start == 6'd0) && (col == 3'(SIDE_WIDTH - 1));
  assign bitboard_valid = (state == DONE);
  assign parse_error    = (state == ERR);
  assign busy           = (state == RECV);

  always_comb begin
    shadow_nxt        = shadow;
    shadow_nxt[index] = is_set;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        if (is_illegal)     state_nxt = ERR;
        else if (is_square) state_nxt = RECV;
      end
      RECV: if (accept) begin
        if (is_illegal)                    state_nxt = ERR;
        else if (is_square && last_square) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ATTACK_BOARD_POPCOUNT_EN
  logic [6:0] set_count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shadow    <= '0;
      bitboard  <= '0;
      index     <= 6'(BOARD_SQUARES - SIDE_WIDTH);
      row_start <= 6'(BOARD_SQUARES - SIDE_WIDTH);
      col       <= '0;
`ifdef ATTACK_BOARD_POPCOUNT_EN
      set_count    <= '0;
      attack_count <= '0;
`endif
    end else begin
      state <= state_nxt;
      if ((state == DONE) || (state == ERR)) begin
        shadow    <= '0;
        index     <= 6'(BOARD_SQUARES - SIDE_WIDTH);
        row_start <= 6'(BOARD_SQUARES - SIDE_WIDTH);
        col       <= '0;
`ifdef ATTACK_BOARD_POPCOUNT_EN
        set_count <= '0;
`endif
      end else if (accept && is_square) begin
        shadow <= shadow_nxt;
        if (col == 3'(SIDE_WIDTH - 1)) begin
          col       <= '0;
          row_start <= row_start - 6'(SIDE_WIDTH);
          index     <= row_start - 6'(SIDE_WIDTH);
        end else begin
          col   <= col + 3'd1;
          index <= index + 6'd1;
        end
`ifdef ATTACK_BOARD_POPCOUNT_EN
        set_count <= set_count + {6'd0, is_set};
`endif
        // Publish on the final square so bitboard is already valid while bitboard_valid is high.
        if (last_square) begin
          bitboard <= shadow_nxt;
`ifdef ATTACK_BOARD_POPCOUNT_EN
          attack_count <= set_count + {6'd0, is_set};
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_attack_board_parser.sv
// Directed bench for attack_board_parser; attack_count is checked when ATTACK_BOARD_POPCOUNT_EN is defined.
module tb_attack_board_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [63:0] bitboard;
  logic        bitboard_valid;
  logic        parse_error;
  logic        busy;
`ifdef ATTACK_BOARD_POPCOUNT_EN
  logic [6:0]  attack_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  attack_board_parser dut (
    .clk            (clk),
    .reset          (reset),
    .char_in        (char_in),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .bitboard       (bitboard),
    .bitboard_valid (bitboard_valid),
    .parse_error    (parse_error),
`ifdef ATTACK_BOARD_POPCOUNT_EN
    .attack_count   (attack_count),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (bitboard_valid) valid_cnt++;
      if (parse_error)    err_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte and waits (bounded) for its handshake; returns #1 after the accepting edge.
  task automatic send_char(input logic [7:0] c);
    logic hs;
    int   cyc;
    char_in    = c;
    char_valid = 1'b1;
    hs  = 1'b0;
    cyc = 0;
    while (!hs && cyc < 20) begin
      hs = char_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    char_valid = 1'b0;
    if (!hs) chk("handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_run(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) send_char(c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] stream [128];
  int vbase, ebase;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_char_ready", {63'd0, char_ready}, 64'd0);
    chk("rst_bitboard", bitboard, 64'd0);
    chk("rst_valid", {63'd0, bitboard_valid}, 64'd0);
    chk("rst_error", {63'd0, parse_error}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", {63'd0, char_ready}, 64'd1);

    // Board 1: X then 63 dots, LF after every rank except the last
    vbase = valid_cnt;
    send_char(8'h58);
    chk("b1_busy", {63'd0, busy}, 64'd1);
    send_run(8'h2E, 7);
    send_char(8'h0A);
    for (int r = 1; r < 8; r++) begin
      send_run(8'h2E, 8);
      if (r < 7) send_char(8'h0A);
    end
    chk("b1_valid", {63'd0, bitboard_valid}, 64'd1);
    chk("b1_board", bitboard, 64'h0100_0000_0000_0000);
    chk("b1_ready_low", {63'd0, char_ready}, 64'd0);
    chk("b1_busy_done", {63'd0, busy}, 64'd0);
`ifdef ATTACK_BOARD_POPCOUNT_EN
    chk("b1_count", {57'd0, attack_count}, 64'd1);
`endif
    tick();
    chk("b1_valid_drop", {63'd0, bitboard_valid}, 64'd0);
    chk("b1_pulses", 64'(valid_cnt - vbase), 64'd1);

    // Board 2: 63 dots then X lands on bit 7
    send_run(8'h2E, 63);
    send_char(8'h58);
    chk("b2_board", bitboard, 64'h0000_0000_0000_0080);
    tick();

    // Board 3: top rank all set
    send_run(8'h58, 8);
    send_run(8'h2E, 56);
    chk("b3_board", bitboard, 64'hFF00_0000_0000_0000);
`ifdef ATTACK_BOARD_POPCOUNT_EN
    chk("b3_count", {57'd0, attack_count}, 64'd8);
`endif
    tick();

    // Illegal byte after 20 squares, then 64 lowercase x
    ebase = err_cnt;
    send_run(8'h2E, 20);
    send_char(8'h51);
    chk("err_pulse", {63'd0, parse_error}, 64'd1);
    chk("err_keep_board", bitboard, 64'hFF00_0000_0000_0000);
    chk("err_busy", {63'd0, busy}, 64'd0);
    tick();
    chk("err_drop", {63'd0, parse_error}, 64'd0);
    chk("err_pulses", 64'(err_cnt - ebase), 64'd1);
    send_run(8'h78, 64);
    chk("fold_board", bitboard, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef ATTACK_BOARD_POPCOUNT_EN
    chk("fold_count", {57'd0, attack_count}, 64'd64);
`endif
    tick();

    // Back-to-back boards with char_valid held high
    for (int i = 0; i < 128; i++) stream[i] = 8'h2E;
    for (int i = 56; i < 64; i++) stream[i] = 8'h58;
    for (int i = 72; i < 80; i++) stream[i] = 8'h58;
    begin
      int idx, cyc, ready_low, nv;
      logic hs;
      idx = 0; cyc = 0; ready_low = 0; nv = 0;
      char_valid = 1'b1;
      while (idx < 128 && cyc < 400) begin
        char_in = stream[idx];
        hs = char_ready;
        if (!hs) ready_low++;
        if (bitboard_valid) begin
          nv++;
          if (nv == 1) chk("b2b_first_board", bitboard, 64'h0000_0000_0000_00FF);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) idx++;
      end
      char_valid = 1'b0;
      chk("b2b_done_in_budget", 64'(idx), 64'd128);
      chk("b2b_ready_low", 64'(ready_low), 64'd1);
      chk("b2b_first_valid_seen", 64'(nv), 64'd1);
      chk("b2b_final_ready_low", {63'd0, char_ready}, 64'd0);
      chk("b2b_final_valid", {63'd0, bitboard_valid}, 64'd1);
      chk("b2b_second_board", bitboard, 64'h00FF_0000_0000_0000);
    end
    tick();

    // Reset mid-board, then a full empty board
    send_run(8'h58, 30);
    reset = 1'b1;
    tick();
    chk("mid_rst_board", bitboard, 64'd0);
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_ready", {63'd0, char_ready}, 64'd0);
    reset = 1'b0;
    vbase = valid_cnt;
    tick();
    chk("post_rst_no_valid", 64'(valid_cnt - vbase), 64'd0);
    send_run(8'h2E, 64);
    tick();
    chk("post_rst_board", bitboard, 64'd0);
    chk("post_rst_pulses", 64'(valid_cnt - vbase), 64'd1);
`ifdef ATTACK_BOARD_POPCOUNT_EN
    chk("post_rst_count", {57'd0, attack_count}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/attack_board_parser.md
Name: attack_board_parser

Overview:
- Character-stream receiver that rebuilds a 64-bit attack bitboard from the text form the attack-display blocks print.
- Sits behind the UART/host byte path.
- Lets the host inject expected attack maps for the on-chip compare against the move generator.
- Bit mapping matches the display blocks: the first square character is bit 56, scanning runs left to right within a rank, ranks run downward, and the 64th square is bit 7.

Parameters:
- SET_CHAR, "X", character that marks an attacked square (bit = 1).
- CLEAR_CHAR, ".", character that marks an unattacked square (bit = 0).
- CASE_FOLD, 1, when 1, the lowercase form of SET_CHAR is also accepted as a set square.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- char_in  input  8  ASCII byte from the host stream
- char_valid  input  1  char_in is valid this cycle
- char_ready  output  1  parser accepts char_in this cycle
- bitboard  output  64  last completed attack map
- bitboard_valid  output  1  one-cycle pulse when bitboard is updated
- parse_error  output  1  one-cycle pulse on an illegal character
- busy  output  1  a board is partially received

Behaviour:
- Reset is clk, synchronous, active-high. Reset values:
  - bitboard = 0, bitboard_valid = 0, parse_error = 0, busy = 0, char_ready = 0 during reset.
  - state = IDLE, internal square count = 0, row_start = 56, col = 0.
- A byte is consumed only when char_valid && char_ready. char_ready = 1 in IDLE and RECV, 0 in DONE and ERR.
- Character classes:
  - SET_CHAR (plus its lowercase form if CASE_FOLD) -> square bit 1.
  - CLEAR_CHAR -> square bit 0.
  - Space (0x20), CR (0x0D), LF (0x0A), TAB (0x09) -> ignored; no count change.
  - Any other byte -> illegal.
- Square mapping: a working index starts at row_start = 56 with col = 0.
  - Each square writes shadow[index] and increments index.
  - On col == 7: col resets to 0, row_start <= row_start - 8, index <= new row_start.
  - The 64th square lands on bit 7.
- States:
  - IDLE: whitespace is ignored. A square char writes the first square, sets busy = 1, and moves to RECV. An illegal char moves to ERR.
  - RECV: square chars fill the shadow register. When the 64th square is accepted, move to DONE. An illegal char moves to ERR. Whitespace is ignored.
  - DONE (1 cycle): bitboard <= shadow, bitboard_valid = 1, busy = 0, counters re-armed, next state IDLE.
  - ERR (1 cycle): parse_error = 1, shadow discarded, bitboard unchanged, busy = 0, counters re-armed, next state IDLE.
- Latency: bitboard_valid asserts the cycle after the 64th square byte handshake. bitboard holds until the next DONE.
- The shadow register is built separately, so bitboard never exposes a partial board.
- Back-to-back boards: the byte presented during DONE/ERR is stalled (char_ready = 0) and accepted in IDLE the next cycle.
- Reset mid-board: the partial board is dropped and bitboard clears to 0.
- Title lines are not supported. Any non-square, non-whitespace byte is an error, so the host strips titles.

Optional Feature:
- Macro ATTACK_BOARD_POPCOUNT_EN.
- When defined:
  - Adds output attack_count [6:0], the number of set bits in bitboard, registered in the same DONE cycle as bitboard (0..64).
  - Reset value 0.
  - Counting is incremental: +1 per SET square into a shadow counter, copied in DONE.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - ASCII constants (CHAR_SPACE, CHAR_CR, CHAR_LF, CHAR_TAB).
  - SIDE_WIDTH = 8, BOARD_SQUARES = 64.
  - The state enum (IDLE, RECV, DONE, ERR), shared with the display blocks.
- One natural sub-module, attack_char_classify: combinational byte -> {is_set, is_clear, is_space, is_illegal}, driven by SET_CHAR/CLEAR_CHAR/CASE_FOLD. It is reused by later board-text parsers.

Test Plan:
- Stream "X" then 63 "." with LF after every 8 -> bitboard = 0x0100_0000_0000_0000; bitboard_valid pulses once; attack_count = 1 when enabled.
- 63 "." then "X" -> bitboard = 0x0000_0000_0000_0080.
- Rank 8 all "X", rest "." -> bitboard = 0xFF00_0000_0000_0000, attack_count = 8.
- 20 squares then "Q" -> parse_error pulses 1 cycle, bitboard retains its prior value. Then a full board of 64 "x" with CASE_FOLD=1 -> bitboard = all ones, attack_count = 64.
- Two boards back-to-back with char_valid held high -> char_ready drops for exactly 1 cycle after each 64th square; both bitboard_valid pulses occur and the second board is correct.
- Reset asserted after 30 squares, then a full board of "." -> bitboard = 0, with exactly one bitboard_valid, after the post-reset board only.
